wb_collector: RTL

Write-back collector for the execute stage. Tracks every operation issued into the fixed-latency execute units (logic, adder, shifter, aux), each a DEPTH-stage pipeline. Captures the matching unit's result exactly when it emerges, and drives the register-bank write port. Keeps a per-register scoreboard of in-flight writes so the issue stage can detect RAW hazards.

---
 rtl/wb_collector_if.sv | 48 ++++
 rtl/wb_collector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_collector_if.sv
// ---------------------------------------------------------------------------
// wb_collector_if
//
// Purpose: groups the issue-side control and the register-bank write port
// of the write-back collector into one bundle.
//
// Signals:
//   issue_valid  1   an operation enters the execute units this cycle
//   issue_rd     5   destination register of the issued operation
//   issue_unit   2   producing unit: 0 logic, 1 adder, 2 shifter, 3 aux
//   flush        1   kill all in-flight operations (branch redirect)
//   regwr_en     1   register-bank write strobe
//   regwr_addr   5   register-bank write address
//   regwr_data   32  register-bank write data
//
// Modports:
//   master  issue stage / environment: drives issue_* and flush, observes regwr_*
//   slave   wb_collector: observes issue_* and flush, drives regwr_*
// ---------------------------------------------------------------------------
interface wb_collector_if;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_unit;
    logic        flush;
    logic        regwr_en;
    logic [4:0]  regwr_addr;
    logic [31:0] regwr_data;

    modport master (
        output issue_valid,
        output issue_rd,
        output issue_unit,
        output flush,
        input  regwr_en,
        input  regwr_addr,
        input  regwr_data
    );

    modport slave (
        input  issue_valid,
        input  issue_rd,
        input  issue_unit,
        input  flush,
        output regwr_en,
        output regwr_addr,
        output regwr_data
    );
endinterface

// File: rtl/wb_collector.sv
// ---------------------------------------------------------------------------
// wb_collector
//
// Purpose: write-back collector for the execute stage. Every operation
// issued into the fixed-latency execute units (logic, adder, shifter, aux,
// each DEPTH stages deep) is followed by a tag pipeline of the same depth.
// When a tag reaches the last stage, the matching unit's result is on its
// bus and is registered onto the register-bank write port. A per-register
// counter of in-flight writes drives busy_mask and the RAW hazard output.
//
// Parameters:
//   DEPTH  pipeline depth of every execute unit (1..8)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   bus (slave)           issue_valid/rd/unit, flush in; regwr_en/addr/data out
//   result_logic/add/shift/aux  32-bit unit result buses
//   query_rs1, query_rs2  source registers of the operation being considered
//   hazard                a queried source has a pending write
//   busy_mask             bit r set when register r has a pending write
//   fwd_rs1/2_valid/data  forwarded retire-slot value (WB_BYPASS_EN only)
//
// Optional feature: define WB_BYPASS_EN to forward the retiring value to the
// query ports and suppress the hazard it would otherwise raise.
// ---------------------------------------------------------------------------
module wb_collector #(
    parameter int DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_collector_if.slave        bus,
    input  logic [31:0]          result_logic,
    input  logic [31:0]          result_add,
    input  logic [31:0]          result_shift,
    input  logic [31:0]          result_aux,
    input  logic [4:0]           query_rs1,
    input  logic [4:0]           query_rs2,
    output logic                 hazard,
    output logic [31:0]          busy_mask
`ifdef WB_BYPASS_EN
    ,
    output logic                 fwd_rs1_valid,
    output logic                 fwd_rs2_valid,
    output logic [31:0]          fwd_rs1_data,
    output logic [31:0]          fwd_rs2_data
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    // Tag pipeline: stage k describes the operation currently in stage k of
    // every execute unit. Only the valid bits are reset/flushed.
    logic [DEPTH-1:0]       tag_vld_p;
    logic [DEPTH-1:0][4:0]  tag_rd_p;
    logic [DEPTH-1:0][1:0]  tag_unit_p;

    // Pending-write counters, one per architectural register.
    logic [CW-1:0]          count [32];

    logic                   iss_cnt;
    logic                   ret_vld;
    logic [4:0]             ret_rd;
    logic [31:0]            ret_data;
    logic                   byp1;
    logic                   byp2;
    logic                   pend1;
    logic                   pend2;

    function automatic logic [31:0] select_result(
        input logic [1:0]  unit,
        input logic [31:0] r_logic,
        input logic [31:0] r_add,
        input logic [31:0] r_shift,
        input logic [31:0] r_aux
    );
        logic [31:0] sel;
        case (unit)
            2'd0:    sel = r_logic;
            2'd1:    sel = r_add;
            2'd2:    sel = r_shift;
            default: sel = r_aux;
        endcase
        return sel;
    endfunction

    // Simultaneous increment and decrement cancel.
    function automatic logic [CW-1:0] count_next(
        input logic [CW-1:0] cur,
        input logic          inc,
        input logic          dec
    );
        logic [CW-1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = cur + CW'(1);
        end else if (dec && !inc) begin
            nxt = cur - CW'(1);
        end
        return nxt;
    endfunction

    // r0 writes ride the pipeline but never touch the scoreboard or the bank.
    assign iss_cnt  = bus.issue_valid && (bus.issue_rd != 5'd0);
    assign ret_rd   = tag_rd_p[DEPTH-1];
    assign ret_vld  = tag_vld_p[DEPTH-1] && (ret_rd != 5'd0);
    assign ret_data = select_result(tag_unit_p[DEPTH-1], result_logic,
                                    result_add, result_shift, result_aux);

    // ---- tag pipeline: stage 0 loads issue, stage k loads stage k-1 ----
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= bus.issue_valid;
            for (int k = 1; k < DEPTH; k++) begin
                tag_vld_p[k] <= tag_vld_p[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_rd_p[0]   <= bus.issue_rd;
        tag_unit_p[0] <= bus.issue_unit;
        for (int k = 1; k < DEPTH; k++) begin
            tag_rd_p[k]   <= tag_rd_p[k-1];
            tag_unit_p[k] <= tag_unit_p[k-1];
        end
    end

    // ---- scoreboard update: issue increments, retire decrements ----
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int r = 0; r < 32; r++) begin
                count[r] <= '0;
            end
        end else begin
            count[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                count[r] <= count_next(count[r],
                                       iss_cnt && (bus.issue_rd == 5'(r)),
                                       ret_vld && (ret_rd == 5'(r)));
            end
        end
    end

    // ---- retire stage: register the write port ----
    // A flush in the retire cycle kills the write; addr/data then hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.regwr_en   <= 1'b0;
            bus.regwr_addr <= 5'd0;
            bus.regwr_data <= 32'd0;
        end else begin
            bus.regwr_en <= ret_vld && !bus.flush;
            if (ret_vld && !bus.flush) begin
                bus.regwr_addr <= ret_rd;
                bus.regwr_data <= ret_data;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < 32; r++) begin
            busy_mask[r] = (count[r] != '0);
        end
    end

`ifdef WB_BYPASS_EN
    // Forwarding is only safe when the retiring write is the sole pending
    // write to that register; a younger in-flight write keeps the hazard.
    assign byp1 = ret_vld && (ret_rd == query_rs1) && (query_rs1 != 5'd0) &&
                  (count[query_rs1] == CW'(1));
    assign byp2 = ret_vld && (ret_rd == query_rs2) && (query_rs2 != 5'd0) &&
                  (count[query_rs2] == CW'(1));

    assign fwd_rs1_valid = byp1;
    assign fwd_rs2_valid = byp2;
    assign fwd_rs1_data  = ret_data;
    assign fwd_rs2_data  = ret_data;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // hazard depends only on query_* and registered state.
    assign pend1  = (query_rs1 != 5'd0) && busy_mask[query_rs1];
    assign pend2  = (query_rs2 != 5'd0) && busy_mask[query_rs2];
    assign hazard = (pend1 && !byp1) || (pend2 && !byp2);

endmodule
